// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage and its decode-side consumers:
// redirect codes, the NOP encoding and the fetch FSM state type.
package fetch_pkg;

  // Redirect codes driven by decode on PCSrcD
  localparam logic [2:0] PCSRC_SEQ = 3'b000;
  localparam logic [2:0] PCSRC_BR  = 3'b001;
  localparam logic [2:0] PCSRC_J   = 3'b010;
  localparam logic [2:0] PCSRC_JR  = 3'b011;
  localparam logic [2:0] PCSRC_JAL = 3'b100;

  // Encoding presented to decode when IF/ID is empty
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

  // True for the codes that change control flow; 101..111 behave as sequential
  function automatic logic is_redirect(input logic [2:0] pcsrc);
    return (pcsrc != PCSRC_SEQ) && (pcsrc <= PCSRC_JAL);
  endfunction

endpackage

// File: rtl/fetch_unit_ifid.sv
// IF/ID pipeline register. Load captures a new instruction, bubble empties
// the stage (NOP, valid low, PC kept for trace), otherwise the contents hold.
module ifid_register
  import fetch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              bubble,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [DATA_W-1:0] pc_in,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] pc_normal,
  output logic              valid
);

  // IF/ID contents: load wins over bubble, anything else holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr     <= DATA_W'(NOP_INSTR);
      pc_normal <= '0;
      valid     <= 1'b0;
    end else if (load) begin
      instr     <= instr_in;
      pc_normal <= pc_in;
      valid     <= 1'b1;
    end else if (bubble) begin
      instr     <= DATA_W'(NOP_INSTR);
      valid     <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: fetch PC, next-PC selection from decode redirects,
// single-outstanding instruction-memory port with a one-word skid buffer, and
// the IF/ID register feeding decode. Wrong-path words are squashed via drop.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [2:0]  PCSrcD,
  input  logic [31:0] PCBranchD,
  input  logic [31:0] PCJumpD,
  input  logic [31:0] PCJrD,
  input  logic        StallD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstructionD,
  output logic [31:0] PCnormalD,
  output logic        ValidD,
  output logic [31:0] PCF
);

  fetch_state_e state, state_next;

  logic [31:0] pc_next;
  logic [31:0] pc_seq;
  logic [31:0] redirect_target;
  logic        drop, drop_next;
  logic        accept;
  logic        redirect;
  logic        skid_load;
  logic [31:0] skid_instr;
  logic        ifid_load;
  logic        ifid_bubble;
  logic [31:0] ifid_instr;

  // Decode can take a word when it is empty or not stalled; a control
  // instruction only acts once it actually leaves decode.
  assign accept    = !ValidD || !StallD;
  assign redirect  = ValidD && !StallD && is_redirect(PCSrcD);
  assign pc_seq    = PCF + 32'd4;
  assign imem_addr = PCF;

  // Redirect target selection; non-redirect codes never use the result
  always_comb begin
    redirect_target = PCF;
    case (PCSrcD)
      PCSRC_BR:            redirect_target = PCBranchD;
      PCSRC_J, PCSRC_JAL:  redirect_target = PCJumpD;
      PCSRC_JR:            redirect_target = PCJrD;
      default:             redirect_target = PCF;
    endcase
  end

  // State, fetch PC and wrong-path drop flag
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= BOOT;
      PCF   <= RESET_PC;
      drop  <= 1'b0;
    end else begin
      state <= state_next;
      PCF   <= pc_next;
      drop  <= drop_next;
    end
  end

  // Skid buffer: holds a response that decode could not take yet
  always_ff @(posedge Clock) begin
    if (skid_load) begin
      skid_instr <= imem_rdata;
    end
  end

  // Next state, next PC, memory request and IF/ID controls
  always_comb begin
    state_next = state;
    pc_next    = PCF;
    drop_next  = drop;
    imem_req   = 1'b0;
    skid_load  = 1'b0;
    ifid_load  = 1'b0;
    ifid_instr = imem_rdata;

    case (state)
      BOOT: begin
        state_next = ISSUE;
      end

      ISSUE: begin
        imem_req = !redirect;
        if (redirect) begin
          pc_next = redirect_target;
        end else begin
          state_next = WAIT;
        end
      end

      WAIT: begin
        if (redirect) begin
          pc_next   = redirect_target;
          drop_next = 1'b1;
        end
        if (imem_valid) begin
          if (drop || redirect) begin
            // Wrong-path word: throw it away and restart at the current PC
            drop_next  = 1'b0;
            state_next = ISSUE;
          end else if (accept) begin
            ifid_load  = 1'b1;
            pc_next    = pc_seq;
            state_next = ISSUE;
          end else begin
            skid_load  = 1'b1;
            state_next = HOLD;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_next    = redirect_target;
          state_next = ISSUE;
        end else if (accept) begin
          ifid_load  = 1'b1;
          ifid_instr = skid_instr;
          pc_next    = pc_seq;
          state_next = ISSUE;
        end
      end

      default: begin
        state_next = BOOT;
      end
    endcase

    ifid_bubble = accept && !ifid_load;
  end

  // PCF still names the word being delivered, so its successor is PCF+4
  ifid_register #(
    .DATA_W (32)
  ) u_ifid (
    .clk       (Clock),
    .rst_n     (Resetn),
    .load      (ifid_load),
    .bubble    (ifid_bubble),
    .instr_in  (ifid_instr),
    .pc_in     (pc_seq),
    .instr     (InstructionD),
    .pc_normal (PCnormalD),
    .valid     (ValidD)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a simple fixed-latency memory model.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic [2:0]  PCSrcD = 3'b000;
  logic [31:0] PCBranchD = 32'h0;
  logic [31:0] PCJumpD = 32'h0;
  logic [31:0] PCJrD = 32'h0;
  logic        StallD = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] InstructionD;
  logic [31:0] PCnormalD;
  logic        ValidD;
  logic [31:0] PCF;

  int checks = 0;
  int errors = 0;

  // memory model state
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;
  logic        mem_en = 1'b1;

  fetch_unit #(.RESET_PC(32'h0040_0000)) dut (
    .Clock        (Clock),
    .Resetn       (Resetn),
    .PCSrcD       (PCSrcD),
    .PCBranchD    (PCBranchD),
    .PCJumpD      (PCJumpD),
    .PCJrD        (PCJrD),
    .StallD       (StallD),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .InstructionD (InstructionD),
    .PCnormalD    (PCnormalD),
    .ValidD       (ValidD),
    .PCF          (PCF)
  );

  always #5 Clock = ~Clock;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h8C00_0000;
  endfunction

  // One clock: sample the request mid-cycle, then advance the memory model
  task automatic tick();
    logic        r;
    logic [31:0] a;
    @(negedge Clock);
    r = imem_req;
    a = imem_addr;
    @(posedge Clock);
    #1;
    if (mem_en) begin
      imem_valid = 1'b0;
      if (r) begin
        mem_cnt  = mem_lat;
        mem_addr = a;
      end
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = word_of(mem_addr);
        end
      end
    end
  endtask

  task automatic reset_dut(input int lat);
    Resetn = 1'b0;
    StallD = 1'b0;
    PCSrcD = 3'b000;
    imem_valid = 1'b0;
    mem_cnt = 0;
    mem_lat = lat;
    mem_en = 1'b1;
    tick();
    tick();
    Resetn = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (ValidD !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++; if (ValidD !== 1'b1) begin errors++; $display("FAIL %s_wait_valid: ValidD=%b want 1", tag, ValidD); end
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    mem_lat = 1;
    mem_cnt = 0;
    mem_en = 1'b1;
    tick();
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", ValidD); end
    checks++; if (InstructionD !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", InstructionD); end
    checks++; if (PCnormalD !== 32'h0) begin errors++; $display("FAIL rst_pcn: got %h want 0", PCnormalD); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
    checks++; if (imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL rst_addr: got %h want 00400000", imem_addr); end
    checks++; if (PCF !== 32'h0040_0000) begin errors++; $display("FAIL rst_pcf: got %h want 00400000", PCF); end
    Resetn = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL seq_c1_req: got %b want 0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL seq_c2_req: req=%b addr=%h want 1 00400000", imem_req, imem_addr); end
    tick();
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL seq_c3_valid: got %b want 0", ValidD); end
    tick();
    checks++; if (ValidD !== 1'b1) begin errors++; $display("FAIL seq_c4_valid: got %b want 1", ValidD); end
    checks++; if (InstructionD !== word_of(32'h0040_0000)) begin errors++; $display("FAIL seq_c4_instr: got %h want %h", InstructionD, word_of(32'h0040_0000)); end
    checks++; if (PCnormalD !== 32'h0040_0004) begin errors++; $display("FAIL seq_c4_pcn: got %h want 00400004", PCnormalD); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0004) begin errors++; $display("FAIL seq_c4_req: req=%b addr=%h want 1 00400004", imem_req, imem_addr); end
    tick();
    checks++; if (ValidD !== 1'b0 || InstructionD !== 32'h0 || PCnormalD !== 32'h0040_0004) begin errors++; $display("FAIL seq_c5_bubble: v=%b i=%h pcn=%h want 0 0 00400004", ValidD, InstructionD, PCnormalD); end
    tick();
    checks++; if (ValidD !== 1'b1 || InstructionD !== word_of(32'h0040_0004)) begin errors++; $display("FAIL seq_c6_instr: v=%b i=%h want 1 %h", ValidD, InstructionD, word_of(32'h0040_0004)); end
    checks++; if (PCnormalD !== 32'h0040_0008) begin errors++; $display("FAIL seq_c6_pcn: got %h want 00400008", PCnormalD); end
    checks++; if (imem_addr !== 32'h0040_0008) begin errors++; $display("FAIL seq_c6_addr: got %h want 00400008", imem_addr); end
  endtask

  // Continues from test_reset: ISSUE, word of 0x400004 in D
  task automatic test_stall();
    StallD = 1'b1;
    tick();
    checks++; if (ValidD !== 1'b1 || InstructionD !== word_of(32'h0040_0004) || PCnormalD !== 32'h0040_0008) begin errors++; $display("FAIL stall_c1_hold: v=%b i=%h pcn=%h", ValidD, InstructionD, PCnormalD); end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (dut.state !== HOLD) begin errors++; $display("FAIL stall_hold_state%0d: got %0d want %0d", k, dut.state, HOLD); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_no_req%0d: got %b want 0", k, imem_req); end
      checks++; if (ValidD !== 1'b1 || InstructionD !== word_of(32'h0040_0004) || PCnormalD !== 32'h0040_0008) begin errors++; $display("FAIL stall_hold_ifid%0d: v=%b i=%h pcn=%h", k, ValidD, InstructionD, PCnormalD); end
    end
    StallD = 1'b0;
    tick();
    checks++; if (ValidD !== 1'b1 || InstructionD !== word_of(32'h0040_0008)) begin errors++; $display("FAIL stall_release_instr: v=%b i=%h want 1 %h", ValidD, InstructionD, word_of(32'h0040_0008)); end
    checks++; if (PCnormalD !== 32'h0040_000C) begin errors++; $display("FAIL stall_release_pcn: got %h want 0040000c", PCnormalD); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_000C) begin errors++; $display("FAIL stall_release_req: req=%b addr=%h want 1 0040000c", imem_req, imem_addr); end
    tick();
    tick();
    checks++; if (ValidD !== 1'b1 || InstructionD !== word_of(32'h0040_000C) || PCnormalD !== 32'h0040_0010) begin errors++; $display("FAIL stall_next_word: v=%b i=%h pcn=%h want 1 %h 00400010", ValidD, InstructionD, PCnormalD, word_of(32'h0040_000C)); end
  endtask

  // Continues from test_stall: ISSUE, PCF 0x400010, ValidD high
  task automatic test_reserved_pcsrc();
    PCSrcD = 3'b110;
    PCBranchD = 32'hDEAD_0000;
    PCJumpD = 32'hDEAD_1000;
    PCJrD = 32'hDEAD_2000;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0010) begin errors++; $display("FAIL pcsrc110_req: req=%b addr=%h want 1 00400010", imem_req, imem_addr); end
    tick();
    checks++; if (PCF !== 32'h0040_0010) begin errors++; $display("FAIL pcsrc110_pcf_wait: got %h want 00400010", PCF); end
    tick();
    checks++; if (ValidD !== 1'b1 || PCnormalD !== 32'h0040_0014 || PCF !== 32'h0040_0014) begin errors++; $display("FAIL pcsrc110_advance: v=%b pcn=%h pcf=%h want 1 00400014 00400014", ValidD, PCnormalD, PCF); end
    PCSrcD = 3'b000;
  endtask

  task automatic test_branch_drop();
    int   n;
    logic saw_valid;
    reset_dut(3);
    wait_valid("br");
    StallD = 1'b1;
    tick();
    checks++; if (dut.state !== WAIT || ValidD !== 1'b1) begin errors++; $display("FAIL br_wait_setup: state=%0d v=%b want %0d 1", dut.state, ValidD, WAIT); end
    StallD = 1'b0;
    PCSrcD = PCSRC_BR;
    PCBranchD = 32'h0040_0100;
    tick();
    checks++; if (ValidD !== 1'b0 || InstructionD !== 32'h0) begin errors++; $display("FAIL br_bubble: v=%b i=%h want 0 0", ValidD, InstructionD); end
    checks++; if (PCF !== 32'h0040_0100) begin errors++; $display("FAIL br_pcf: got %h want 00400100", PCF); end
    PCSrcD = 3'b000;
    #1;
    n = 0;
    saw_valid = 1'b0;
    while (imem_req !== 1'b1 && n < 12) begin
      tick();
      if (ValidD === 1'b1) saw_valid = 1'b1;
      n++;
    end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL br_req_timeout: req=%b want 1", imem_req); end
    checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL br_late_word_used: saw ValidD=%b want 0", saw_valid); end
    checks++; if (imem_addr !== 32'h0040_0100) begin errors++; $display("FAIL br_target_addr: got %h want 00400100", imem_addr); end
    wait_valid("br_target");
    checks++; if (InstructionD !== word_of(32'h0040_0100) || PCnormalD !== 32'h0040_0104) begin errors++; $display("FAIL br_target_word: i=%h pcn=%h want %h 00400104", InstructionD, PCnormalD, word_of(32'h0040_0100)); end
  endtask

  task automatic test_jr_collide();
    reset_dut(1);
    wait_valid("jr");
    StallD = 1'b1;
    tick();
    checks++; if (dut.state !== WAIT || imem_valid !== 1'b1) begin errors++; $display("FAIL jr_setup: state=%0d imem_valid=%b want %0d 1", dut.state, imem_valid, WAIT); end
    StallD = 1'b0;
    PCSrcD = PCSRC_JR;
    PCJrD = 32'h0000_1234;
    tick();
    checks++; if (PCF !== 32'h0000_1234) begin errors++; $display("FAIL jr_pcf: got %h want 00001234", PCF); end
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL jr_dropped: ValidD=%b want 0", ValidD); end
    PCSrcD = 3'b000;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_1234) begin errors++; $display("FAIL jr_req: req=%b addr=%h want 1 00001234", imem_req, imem_addr); end
    tick();
    tick();
    checks++; if (ValidD !== 1'b1 || InstructionD !== word_of(32'h0000_1234) || PCnormalD !== 32'h0000_1238) begin errors++; $display("FAIL jr_target_word: v=%b i=%h pcn=%h want 1 %h 00001238", ValidD, InstructionD, PCnormalD, word_of(32'h0000_1234)); end
  endtask

  // Continues from test_jr_collide: ISSUE with ValidD high
  task automatic test_wrap();
    PCSrcD = PCSRC_JR;
    PCJrD = 32'hFFFF_FFFC;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wrap_no_req_on_redirect: got %b want 0", imem_req); end
    tick();
    checks++; if (PCF !== 32'hFFFF_FFFC || ValidD !== 1'b0) begin errors++; $display("FAIL wrap_pcf: pcf=%h v=%b want fffffffc 0", PCF, ValidD); end
    PCSrcD = 3'b000;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req: req=%b addr=%h want 1 fffffffc", imem_req, imem_addr); end
    tick();
    tick();
    checks++; if (ValidD !== 1'b1 || InstructionD !== word_of(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_word: v=%b i=%h want 1 %h", ValidD, InstructionD, word_of(32'hFFFF_FFFC)); end
    checks++; if (PCnormalD !== 32'h0 || PCF !== 32'h0 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_pc: pcn=%h pcf=%h addr=%h want 0 0 0", PCnormalD, PCF, imem_addr); end
  endtask

  task automatic test_reset_mid_wait();
    reset_dut(3);
    wait_valid("rstw");
    tick();
    checks++; if (dut.state !== WAIT) begin errors++; $display("FAIL rstw_setup: state=%0d want %0d", dut.state, WAIT); end
    #2;
    Resetn = 1'b0;
    #1;
    checks++; if (ValidD !== 1'b0 || InstructionD !== 32'h0 || PCnormalD !== 32'h0) begin errors++; $display("FAIL rstw_ifid: v=%b i=%h pcn=%h want 0 0 0", ValidD, InstructionD, PCnormalD); end
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0040_0000 || PCF !== 32'h0040_0000) begin errors++; $display("FAIL rstw_fetch: req=%b addr=%h pcf=%h want 0 00400000 00400000", imem_req, imem_addr, PCF); end
    checks++; if (dut.state !== BOOT) begin errors++; $display("FAIL rstw_state: got %0d want %0d", dut.state, BOOT); end
    mem_en = 1'b0;
    mem_cnt = 0;
    imem_valid = 1'b0;
    tick();
    Resetn = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    tick();
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL rstw_late_c2: ValidD=%b want 0", ValidD); end
    imem_valid = 1'b0;
    tick();
    checks++; if (ValidD !== 1'b0 || dut.state !== WAIT) begin errors++; $display("FAIL rstw_late_c3: v=%b state=%0d want 0 %0d", ValidD, dut.state, WAIT); end
    tick();
    checks++; if (ValidD !== 1'b0 || InstructionD !== 32'h0) begin errors++; $display("FAIL rstw_late_c4: v=%b i=%h want 0 0", ValidD, InstructionD); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_reserved_pcsrc();
    test_branch_drop();
    test_jr_collide();
    test_wrap();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 want finish");
    $fatal(1, "watchdog");
  end

endmodule
